// File: rtl/pc_gen_if.sv
// Next-PC select / fetch-address bundle between the select stage, pc_gen and fetch.
interface pc_gen_if #(
    parameter int PC_WIDTH    = 16,
    parameter int FETCH_WIDTH = 4
);
    logic [2:0]             PC_select;
    logic [PC_WIDTH-1:0]    pc_brch0_tgt;
    logic [PC_WIDTH-1:0]    pc_brch1_tgt;
    logic [PC_WIDTH-1:0]    pc_jump_tgt;
    logic [PC_WIDTH-1:0]    pc_recovery;
    logic [PC_WIDTH-1:0]    pc_bhndlr;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_seq;
    logic                   fetch_valid;
    logic [FETCH_WIDTH-1:0] slot_mask;
    logic [15:0]            redirect_cnt;

    // upstream side: drives the select code and targets, observes fetch state
    modport master (
        output PC_select, pc_brch0_tgt, pc_brch1_tgt, pc_jump_tgt, pc_recovery, pc_bhndlr,
        input  pc, pc_seq, fetch_valid, slot_mask, redirect_cnt
    );

    // pc_gen side
    modport slave (
        input  PC_select, pc_brch0_tgt, pc_brch1_tgt, pc_jump_tgt, pc_recovery, pc_bhndlr,
        output pc, pc_seq, fetch_valid, slot_mask, redirect_cnt
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC register: loads one of eight sources per cycle from the PC_select code,
// derives the next sequential group address and the per-slot valid mask, and
// counts redirects (saturating) for performance debug.
module pc_gen #(
    parameter int                PC_WIDTH    = 16,
    parameter int                FETCH_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = '0
) (
    input  logic       clk,
    input  logic       rst,
    pc_gen_if.slave    bus
);
    localparam int OFF = $clog2(FETCH_WIDTH);

    typedef enum logic [2:0] {
        SEL_BRCH0 = 3'd0,
        SEL_BRCH1 = 3'd1,
        SEL_JUMP  = 3'd2,
        SEL_RECOV = 3'd3,
        SEL_BHNDL = 3'd4,
        SEL_SEQ   = 3'd5,
        SEL_HOLD  = 3'd6,
        SEL_RESET = 3'd7
    } pc_sel_e;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_seq;
    logic                fv_q;
    logic [15:0]         cnt_q;
    pc_sel_e             sel;

    assign sel = pc_sel_e'(bus.PC_select);

    // next group boundary; wraps silently modulo 2^PC_WIDTH
    assign pc_seq = {pc_q[PC_WIDTH-1:OFF], {OFF{1'b0}}} + PC_WIDTH'(FETCH_WIDTH);

    // PC / valid / redirect counter update, one-cycle latency from select to pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            fv_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (sel)
                SEL_BRCH0, SEL_BRCH1, SEL_JUMP, SEL_RECOV, SEL_BHNDL: begin
                    fv_q <= 1'b1;
                    if (cnt_q != 16'hFFFF)
                        cnt_q <= cnt_q + 16'd1;
                    case (sel)
                        SEL_BRCH0: pc_q <= bus.pc_brch0_tgt;
                        SEL_BRCH1: pc_q <= bus.pc_brch1_tgt;
                        SEL_JUMP:  pc_q <= bus.pc_jump_tgt;
                        SEL_RECOV: pc_q <= bus.pc_recovery;
                        default:   pc_q <= bus.pc_bhndlr;
                    endcase
                end
                SEL_SEQ: begin
                    pc_q <= pc_seq;
                    fv_q <= 1'b1;
                end
                SEL_HOLD: ;
                default: begin
                    pc_q <= RESET_VEC;
                    fv_q <= 1'b0;
                end
            endcase
        end
    end

    // slots below the in-group offset of a redirect target are not part of the fetch
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        localparam logic [OFF-1:0] IDX = OFF'(i);
        assign bus.slot_mask[i] = fv_q && (IDX >= pc_q[OFF-1:0]);
    end

    assign bus.pc           = pc_q;
    assign bus.pc_seq       = pc_seq;
    assign bus.fetch_valid  = fv_q;
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/start, mid-group redirect, stall, redirect chain,
// wrap, async reset and counter saturation.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if #(.PC_WIDTH(16), .FETCH_WIDTH(4)) bus ();

    pc_gen #(.PC_WIDTH(16), .FETCH_WIDTH(4), .RESET_VEC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [15:0] pc, input logic fv,
                                input logic [3:0] mask, input logic [15:0] cnt);
        check({tag, ".pc"},   32'(bus.pc), 32'(pc));
        check({tag, ".fv"},   32'(bus.fetch_valid), 32'(fv));
        check({tag, ".mask"}, 32'(bus.slot_mask), 32'(mask));
        check({tag, ".cnt"},  32'(bus.redirect_cnt), 32'(cnt));
    endtask

    // present a code, clock once, land on the following negedge for sampling
    task automatic step(input logic [2:0] code);
        bus.PC_select = code;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.PC_select    = 3'd7;
        bus.pc_brch0_tgt = '0;
        bus.pc_brch1_tgt = '0;
        bus.pc_jump_tgt  = '0;
        bus.pc_recovery  = '0;
        bus.pc_bhndlr    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_state("reset", 16'h0000, 1'b0, 4'b0000, 16'd0);
        rst = 1'b0;

        step(3'd7);
        expect_state("code7", 16'h0000, 1'b0, 4'b0000, 16'd0);
        bus.pc_bhndlr = 16'h0000;
        step(3'd4);
        expect_state("start", 16'h0000, 1'b1, 4'b1111, 16'd1);
        step(3'd5);
        expect_state("seq1", 16'h0004, 1'b1, 4'b1111, 16'd1);
        step(3'd5);
        expect_state("seq2", 16'h0008, 1'b1, 4'b1111, 16'd1);
        step(3'd5);
        expect_state("seq3", 16'h000C, 1'b1, 4'b1111, 16'd1);

        bus.pc_brch0_tgt = 16'h0032;
        step(3'd0);
        expect_state("midgrp", 16'h0032, 1'b1, 4'b1100, 16'd2);
        check("midgrp.pc_seq", 32'(bus.pc_seq), 32'h0034);
        step(3'd5);
        expect_state("midgrp_seq", 16'h0034, 1'b1, 4'b1111, 16'd2);

        for (int k = 0; k < 4; k++) begin
            bus.pc_brch0_tgt = 16'(16'h1111 * (k + 1));
            bus.pc_brch1_tgt = 16'(16'h2222 ^ k);
            bus.pc_jump_tgt  = 16'(16'h0F0F + k);
            bus.pc_recovery  = 16'(16'hABCD - k);
            bus.pc_bhndlr    = 16'(16'h5A5A << k);
            step(3'd6);
            expect_state("stall", 16'h0034, 1'b1, 4'b1111, 16'd2);
        end

        bus.pc_bhndlr = 16'h0040;
        step(3'd4);
        expect_state("to40", 16'h0040, 1'b1, 4'b1111, 16'd3);
        bus.pc_recovery = 16'h0101;
        step(3'd3);
        expect_state("recov", 16'h0101, 1'b1, 4'b1110, 16'd4);
        bus.pc_brch1_tgt = 16'h0200;
        step(3'd1);
        expect_state("brch1", 16'h0200, 1'b1, 4'b1111, 16'd5);
        bus.pc_jump_tgt = 16'h0303;
        step(3'd2);
        expect_state("jump", 16'h0303, 1'b1, 4'b1000, 16'd6);
        check("jump.pc_seq", 32'(bus.pc_seq), 32'h0304);

        bus.pc_bhndlr = 16'hFFFC;
        step(3'd4);
        expect_state("top", 16'hFFFC, 1'b1, 4'b1111, 16'd7);
        check("top.pc_seq", 32'(bus.pc_seq), 32'h0000);
        step(3'd5);
        expect_state("wrap", 16'h0000, 1'b1, 4'b1111, 16'd7);
        step(3'd7);
        expect_state("code7_run", 16'h0000, 1'b0, 4'b0000, 16'd7);
        step(3'd5);
        expect_state("seq_from_rv", 16'h0004, 1'b1, 4'b1111, 16'd7);

        bus.pc_brch1_tgt = 16'h0200;
        step(3'd1);
        expect_state("pre_arst", 16'h0200, 1'b1, 4'b1111, 16'd8);
        bus.PC_select = 3'd6;
        #2 rst = 1'b1;
        #1 expect_state("arst", 16'h0000, 1'b0, 4'b0000, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.pc_brch0_tgt = 16'h0123;
        step(3'd0);
        expect_state("post_arst", 16'h0123, 1'b1, 4'b1000, 16'd1);

        bus.PC_select = 3'd0;
        repeat (65533) @(posedge clk);
        @(negedge clk);
        check("sat.fffe", 32'(bus.redirect_cnt), 32'h0000FFFE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("sat.ffff", 32'(bus.redirect_cnt), 32'h0000FFFF);
        step(3'd2);
        check("sat.hold", 32'(bus.redirect_cnt), 32'h0000FFFF);
        step(3'd5);
        check("sat.seq", 32'(bus.redirect_cnt), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
